// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - 4x4 keypad column scanner with debounce and valid/ready key delivery
module keypad_matrix_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic [3:0] key_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [1:0]    hits;
  logic [3:0]    acc_code;
  state_t        state;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  logic [3:0]    lows;
  logic [2:0]    n_low;
  logic [1:0]    row_idx;
  logic [1:0]    base_hits;
  logic [1:0]    scan_hits;
  logic [3:0]    scan_code;
  logic          sample;
  logic          scan_done;
  logic          single;
  logic          none;
  logic [CW-1:0] cnt_next;
  logic          emit_now;

  // One-cold column drive follows the scan column directly.
  assign key_out   = ~(4'b0001 << col);
  assign sample    = (dwell == DWELL_LAST);
  assign scan_done = sample && (col == 2'd3);
  assign single    = (scan_hits == 2'd1);
  assign none      = (scan_hits == 2'd0);
  assign cnt_next  = cnt + CNT_ONE;

  // A press is emitted on the scan that completes the debounce count.
  assign emit_now = scan_done && single &&
                    (((state == IDLE) && (CNT_ONE == CNT_DONE)) ||
                     ((state == DEBOUNCE) && (scan_code == cand) && (cnt_next == CNT_DONE)));

  // Fold the current column sample into the running scan tally (hits saturates at 2 = multi).
  always_comb begin
    lows  = ~row_sync;
    n_low = {2'b00, lows[0]} + {2'b00, lows[1]} + {2'b00, lows[2]} + {2'b00, lows[3]};
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (lows[i]) row_idx = 2'(i);
    end
    base_hits = (col == 2'd0) ? 2'd0 : hits;
    scan_code = (col == 2'd0) ? 4'd0 : acc_code;
    scan_hits = base_hits;
    if (n_low >= 3'd2) begin
      scan_hits = 2'd2;
    end else if (n_low == 3'd1) begin
      if (base_hits == 2'd0) begin
        scan_hits = 2'd1;
        scan_code = {col, row_idx};
      end else begin
        scan_hits = 2'd2;
      end
    end
  end

  // Two-flop synchronizer on the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= key_in;
      row_sync <= row_meta;
    end
  end

  // Column dwell timing and per-scan accumulation of low rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell    <= '0;
      col      <= 2'd0;
      hits     <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      dwell    <= '0;
      col      <= col + 2'd1;
      hits     <= scan_hits;
      acc_code <= scan_code;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Debounce state machine, one transition per completed scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cand     <= 4'd0;
      cnt      <= '0;
      key_held <= 1'b0;
    end else if (scan_done) begin
      case (state)
        IDLE: begin
          if (single) begin
            cand <= scan_code;
            cnt  <= CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              state    <= PRESSED;
              key_held <= 1'b1;
            end else begin
              state <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (single) begin
            if (scan_code == cand) begin
              if (cnt_next == CNT_DONE) begin
                state    <= PRESSED;
                key_held <= 1'b1;
              end else begin
                cnt <= cnt_next;
              end
            end else begin
              cand <= scan_code;
              cnt  <= CNT_ONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        PRESSED: begin
          if (none) begin
            if (CNT_ONE == CNT_DONE) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else begin
              cnt   <= CNT_ONE;
              state <= RELEASE;
            end
          end
        end
        default: begin
          if (none) begin
            if (cnt_next == CNT_DONE) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt_next;
            end
          end else begin
            state <= PRESSED;
          end
        end
      endcase
    end
  end

  // Output holding register: accept an emit if empty or draining this cycle, else flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (key_valid && key_ready) key_valid <= 1'b0;
      if (emit_now) begin
        if (!key_valid || key_ready) begin
          key_code  <= scan_code;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed bench for keypad_matrix_scanner
module tb_keypad_matrix_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_in;
  logic [3:0]  key_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic        key_held;
  logic        overrun;
  logic [15:0] press_mask = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;

  int         xfer_count   = 0;
  logic [3:0] last_code    = 4'd0;
  int         valid_cycles = 0;
  int         held_cycles  = 0;

  keypad_matrix_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_out   (key_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed (c,r) pulls row r low while column c is driven low.
  always_comb begin
    key_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (press_mask[4*c+r] && !key_out[c]) key_in[r] = 1'b0;
      end
    end
  end

  // Cumulative observation of transfers and output activity.
  always @(posedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) begin
        xfer_count = xfer_count + 1;
        last_code  = key_code;
      end
      if (key_valid) valid_cycles = valid_cycles + 1;
      if (key_held)  held_cycles  = held_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int  x0, v0, h0;
  bit  found;

  initial begin
    // 1: reset values and column stepping
    cycles(3);
    check("rst_key_out", key_out, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_held", key_held, 0);
    rst = 1'b0;
    cycles(7);
    check("col0_dwell", key_out, 4'b1110);
    cycles(1);
    check("col1", key_out, 4'b1101);
    cycles(8);
    check("col2", key_out, 4'b1011);
    cycles(8);
    check("col3", key_out, 4'b0111);
    cycles(8);
    check("col_wrap", key_out, 4'b1110);

    // 2: single clean press of (c2,r1), consumer always ready
    key_ready = 1'b1;
    x0 = xfer_count;
    press_mask[9] = 1'b1;
    cycles(300);
    check("press9_held", key_held, 1);
    check("press9_count", xfer_count - x0, 1);
    check("press9_code", last_code, 9);
    press_mask[9] = 1'b0;
    cycles(40);
    check("release9_still_held", key_held, 1);
    cycles(160);
    check("release9_held", key_held, 0);
    check("release9_no_reemit", xfer_count - x0, 1);
    check("release9_valid", key_valid, 0);

    // 3: bouncing (c0,r3) then stable
    x0 = xfer_count;
    for (int i = 0; i < 6; i++) begin
      press_mask[3] = (i % 2 == 0);
      cycles(20);
    end
    press_mask[3] = 1'b1;
    cycles(200);
    check("bounce_count", xfer_count - x0, 1);
    check("bounce_code", last_code, 3);
    press_mask[3] = 1'b0;
    cycles(200);
    check("bounce_released", key_held, 0);

    // 4: two keys together are ghosting and never reported
    v0 = valid_cycles;
    h0 = held_cycles;
    press_mask[0] = 1'b1;
    press_mask[5] = 1'b1;
    cycles(400);
    check("multi_valid", valid_cycles - v0, 0);
    check("multi_held", held_cycles - h0, 0);
    press_mask[0] = 1'b0;
    press_mask[5] = 1'b0;
    cycles(100);

    // 5: consumer stalled, second press overruns
    check("pre_overrun", overrun, 0);
    key_ready = 1'b0;
    press_mask[3] = 1'b1;
    cycles(200);
    press_mask[3] = 1'b0;
    cycles(200);
    press_mask[12] = 1'b1;
    cycles(200);
    press_mask[12] = 1'b0;
    cycles(200);
    check("stall_valid", key_valid, 1);
    check("stall_code", key_code, 3);
    check("stall_overrun", overrun, 1);
    x0 = xfer_count;
    key_ready = 1'b1;
    cycles(1);
    key_ready = 1'b0;
    check("drain_valid", key_valid, 0);
    check("drain_overrun", overrun, 1);
    check("drain_count", xfer_count - x0, 1);
    check("drain_code", last_code, 3);

    // 6: reset during debounce of (c3,r2), then re-emit after three scans
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (key_out == 4'b0111) found = 1'b1;
    end
    check("align_col3", found, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (key_out == 4'b1110) found = 1'b1;
    end
    check("align_col0", found, 1);
    press_mask[14] = 1'b1;
    cycles(70);
    check("debounce_no_valid", key_valid, 0);
    check("debounce_no_held", key_held, 0);
    rst = 1'b1;
    cycles(2);
    check("mid_rst_key_out", key_out, 4'b1110);
    check("mid_rst_key_code", key_code, 0);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_held", key_held, 0);
    check("mid_rst_overrun", overrun, 0);
    rst = 1'b0;
    cycles(95);
    check("post_rst_not_yet", key_valid, 0);
    cycles(1);
    check("post_rst_valid", key_valid, 1);
    check("post_rst_code", key_code, 14);
    check("post_rst_held", key_held, 1);
    press_mask[14] = 1'b0;
    cycles(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
